// File: rtl/tdm_tx_multi.sv
// Multi-channel TDM serial transmitter. It derives the bit clock from the master clock and
// shifts packed frames out MSB-first into fixed-width slots, free-running.
module tdm_tx_multi #(
  parameter int G_BITS       = 16,
  parameter int G_SLOT_BITS  = 32,
  parameter int G_CHANNELS   = 8,
  parameter int G_SCLK_DIV   = 2,
  parameter int G_FSYNC_MODE = 0
) (
  input  logic                           in_mclk,
  input  logic                           in_reset,
  input  logic [G_CHANNELS*G_BITS-1:0]   in_frame,
  input  logic                           in_frame_strobe,
  output logic                           out_mclk,
  output logic                           out_sclk,
  output logic                           out_fclk,
  output logic                           out_dout,
  output logic                           out_underrun,
  output logic                           out_overrun
);

  localparam int FB    = G_CHANNELS * G_SLOT_BITS;
  localparam int FW    = G_CHANNELS * G_BITS;
  localparam int DIV_W = (G_SCLK_DIV > 2) ? $clog2(G_SCLK_DIV) : 1;
  localparam int BIT_W = (FB > 1) ? $clog2(FB) : 1;
  localparam int OFF_W = (G_SLOT_BITS > 1) ? $clog2(G_SLOT_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(G_SCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(G_SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FB - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(G_SLOT_BITS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [OFF_W-1:0] off_cnt;
  logic             pending;
  logic [FW-1:0]    hold_reg;
  logic [FW-1:0]    shift_reg;

  logic             rise_evt;
  logic             fall_evt;
  logic             frame_start;
  logic             load_now;
  logic             data_slot;
  logic             fclk_nxt;
  logic [BIT_W-1:0] bit_nxt;
  logic [OFF_W-1:0] off_nxt;
  logic [FW-1:0]    src_word;

  assign out_mclk = in_mclk;

  // Next-bit decode: the word feeding the serialiser is the freshly loaded
  // frame on the frame-start edge, so slot 0 MSB leaves on the load edge.
  always_comb begin
    rise_evt    = (div_cnt == DIV_RISE);
    fall_evt    = (div_cnt == DIV_LAST);
    frame_start = (bit_cnt == BIT_LAST);
    load_now    = fall_evt && frame_start;
    bit_nxt     = frame_start ? '0 : bit_cnt + 1'b1;
    off_nxt     = (frame_start || (off_cnt == OFF_LAST)) ? '0 : off_cnt + 1'b1;
    src_word    = frame_start ? (pending ? hold_reg : '0) : shift_reg;
    data_slot   = (int'(off_nxt) < G_BITS);
    fclk_nxt    = (G_FSYNC_MODE == 0) ? (bit_nxt == BIT_LAST) : (bit_nxt == '0);
  end

  always_ff @(posedge in_mclk) begin
    if (in_reset) begin
      div_cnt      <= '0;
      bit_cnt      <= BIT_LAST;
      off_cnt      <= OFF_LAST;
      pending      <= 1'b0;
      hold_reg     <= '0;
      shift_reg    <= '0;
      out_sclk     <= 1'b0;
      out_fclk     <= 1'b0;
      out_dout     <= 1'b0;
      out_underrun <= 1'b0;
      out_overrun  <= 1'b0;
    end else begin
      out_underrun <= 1'b0;
      out_overrun  <= 1'b0;
      div_cnt      <= fall_evt ? '0 : div_cnt + 1'b1;

      if (rise_evt) begin
        out_sclk <= 1'b1;
      end

      if (fall_evt) begin
        out_sclk <= 1'b0;
        bit_cnt  <= bit_nxt;
        off_cnt  <= off_nxt;
        out_fclk <= fclk_nxt;
        out_dout <= data_slot ? src_word[FW-1] : 1'b0;
        // Padding bits leave the shift register untouched.
        shift_reg <= data_slot ? (src_word << 1) : src_word;
        if (frame_start) begin
          pending      <= 1'b0;
          out_underrun <= ~pending;
        end
      end

      // A strobe on the load edge refills holding after the load has taken
      // the old content, so it is never an overrun.
      if (in_frame_strobe) begin
        hold_reg    <= in_frame;
        pending     <= 1'b1;
        out_overrun <= pending && !load_now;
      end
    end
  end

endmodule

// File: doc/tdm_tx_multi.md
# tdm_tx_multi

Parametrised TDM serial transmitter for the I2S-to-TDM path. It takes a packed multi-channel frame from the upstream I2S receivers and divides the master clock into a bit clock. It serialises the frame MSB-first into `G_CHANNELS` slots of `G_SLOT_BITS` bits, free-running frame after frame. It adds configurable slot padding, clock ratio and frame-sync mode, plus underrun/overrun reporting.

## Interface
- `G_BITS`, 16: sample width per channel, ≥1.
- `G_SLOT_BITS`, 32: slot width in bits, ≥ `G_BITS`. The low `G_SLOT_BITS-G_BITS` bits of each slot are zero.
- `G_CHANNELS`, 8: slots per frame, ≥1.
- `G_SCLK_DIV`, 2: `in_mclk` cycles per `out_sclk` period. Must be even and ≥2.
- `G_FSYNC_MODE`, 0: 0 = fclk pulse one bit before slot 0 MSB; 1 = fclk pulse coincident with slot 0 MSB.
- `in_mclk`  in  1  sole clock; all logic on the rising edge.
- `in_reset`  in  1  synchronous, active-high reset.
- `in_frame`  in  `G_CHANNELS*G_BITS`  packed samples; channel 0 in the MSBs.
- `in_frame_strobe`  in  1  one-cycle qualifier; captures `in_frame`.
- `out_mclk`  out  1  combinational copy of `in_mclk`.
- `out_sclk`  out  1  registered bit clock.
- `out_fclk`  out  1  registered frame sync.
- `out_dout`  out  1  registered serial data.
- `out_underrun`  out  1  one-cycle pulse: a frame started with no new data.
- `out_overrun`  out  1  one-cycle pulse: a strobe overwrote unconsumed data.

## Operation
- Derived value: FB = `G_CHANNELS*G_SLOT_BITS` bits per frame.
- Divider `div_cnt` counts 0..`G_SCLK_DIV`-1, wrapping.
- Rising event: `div_cnt == G_SCLK_DIV/2-1`. `out_sclk` <= 1.
- Falling event E: `div_cnt == G_SCLK_DIV-1`. `out_sclk` <= 0.
- Bit counter `bit_cnt` covers 0..FB-1. At each E it advances to b = (`bit_cnt`==FB-1) ? 0 : `bit_cnt`+1.
- At E:
  - `out_dout` <= frame bit b, MSB first. Slot s = b / `G_SLOT_BITS`, offset o = b mod `G_SLOT_BITS`.
  - Data bit = channel s sample bit `G_BITS`-1-o when o < `G_BITS`, else 0.
- At E, `out_fclk` <= (b==FB-1) in mode 0, (b==0) in mode 1. The pulse is one sclk period wide, every frame, including underrun frames.
- Input capture: strobe copies `in_frame` into the holding register and sets `pending`.
  - If `pending` is already set and not consumed this cycle, `out_overrun` pulses; the newest data wins.
- Frame load at E with b==0:
  - If `pending`: shift/frame register <= holding register, `pending` cleared.
  - Else: frame register <= all zeros, `out_underrun` pulses.
- Strobe coinciding with a frame load: the load uses the holding content from before that cycle. The new strobe then refills holding and sets `pending` for the next frame. No overrun is flagged.
- Slot 0 MSB is emitted at the same E as the load; the serialiser must use the loaded data for bit 0.

## Timing
- Reset values: `div_cnt`=0, `bit_cnt`=FB-1, `pending`=0, holding=0, frame=0.
- Reset values of outputs: `out_sclk`, `out_fclk`, `out_dout`, `out_underrun`, `out_overrun` all 0.
- First E occurs `G_SCLK_DIV` mclk cycles after reset deasserts. It starts frame 0 (b=0).
- Mode 0: no fclk precedes frame 0 after reset. Mode 1: fclk is high for frame 0.
- `out_sclk` duty cycle 50%. Data and fclk change only on the mclk edge where sclk falls; receivers sample on sclk rise.
- Strobe-to-air latency: data captured by cycle t is sent from the next frame-start E after t. Worst case is FB·`G_SCLK_DIV` mclk cycles.
- Reset asserted mid-frame: all state returns to reset values on the next mclk edge. The frame is abandoned; no underrun or overrun pulses during reset.
- `out_underrun` and `out_overrun` are exactly one mclk cycle wide.

## Test plan
- Config `G_CHANNELS`=2, `G_BITS`=`G_SLOT_BITS`=16, `G_SCLK_DIV`=2, mode 0. Strobe {0xA5A5,0x0F0F} before the first E. Required: `out_dout` over 32 E's = A5A5 then 0F0F MSB-first. fclk high only during bit 31 of each frame. No underrun.
- Padding, `G_SLOT_BITS`=24, `G_BITS`=16, 2 channels. Strobe {0xFFFF,0x8001}. Required: per slot, 16 data bits then 8 zeros. Frame period = 48 sclk.
- Underrun: one strobe, then none. Required: frame 1 is all zeros and fclk is still pulsed. `out_underrun` is one cycle at each subsequent frame start.
- Overrun: strobe 0x1111 then 0x2222 within one frame. Required: one `out_overrun` pulse, next frame carries 0x2222. Strobe on the frame-load cycle: no overrun.
- Mode 1, `G_SCLK_DIV`=4. Required: sclk is 2 cycles low / 2 cycles high. fclk is high during slot 0 MSB. First E occurs 4 cycles after reset release.
- Assert `in_reset` at bit 10 of a frame. Required: all outputs 0 next cycle. Restart timing is identical to power-up.
